// File: rtl/regfile_gen.sv
// rtl/regfile_gen.sv - register file with dedicated program counter and stack pointer
//
// Purpose:
//   NREGS = 2**SEL_W registers of WIDTH bits. Registers 0..NREGS-3 are general
//   purpose, NREGS-2 is the stack pointer (SP) and NREGS-1 is the program
//   counter (PC). There are two combinational read ports and one write port.
//   PC and SP also have dedicated increment/decrement controls. When any of
//   those updates lands on the same register as a write, the write wins.
//
// Ports:
//   clock     in   1      rising-edge clock
//   notReset  in   1      asynchronous active-low reset
//   aSel      in   SEL_W  read port A select
//   notAOE    in   1      active-low output enable for aBus
//   aBus      out  WIDTH  read port A data (tri-state, high-Z when notAOE = 1)
//   bSel      in   SEL_W  read port B select
//   bBus      out  WIDTH  read port B data
//   wSel      in   SEL_W  write select
//   notLoad   in   1      active-low write enable
//   yBus      in   WIDTH  write data
//   pcInc     in   1      PC += PC_STEP
//   spPush    in   1      SP -= 1
//   spPop     in   1      SP += 1
//   pcOut     out  WIDTH  current PC
//   spOut     out  WIDTH  current SP

module regfile_gen #(
  parameter int WIDTH    = 16,
  parameter int SEL_W    = 3,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic [SEL_W-1:0] aSel,
  input  logic             notAOE,
  output tri   [WIDTH-1:0] aBus,
  input  logic [SEL_W-1:0] bSel,
  output logic [WIDTH-1:0] bBus,
  input  logic [SEL_W-1:0] wSel,
  input  logic             notLoad,
  input  logic [WIDTH-1:0] yBus,
  input  logic             pcInc,
  input  logic             spPush,
  input  logic             spPop,
  output logic [WIDTH-1:0] pcOut,
  output logic [WIDTH-1:0] spOut
);

  localparam int NREGS = 2 ** SEL_W;

  localparam logic [SEL_W-1:0] SP_IDX     = SEL_W'(NREGS - 2);
  localparam logic [SEL_W-1:0] PC_IDX     = SEL_W'(NREGS - 1);
  localparam logic [WIDTH-1:0] PC_STEP_W  = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);

  // With fewer than 4 registers there is no room for SP, PC and a GP register.
  if (SEL_W < 2) begin : g_bad_sel_w
    $error("regfile_gen: SEL_W must be at least 2");
  end

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] a_data;

  // Next-state logic. PC and SP updates are applied first, and the write is
  // applied last, so a write to PC or SP discards the pending increment or
  // decrement for that register.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (pcInc) begin
      regs_d[PC_IDX] = regs_q[PC_IDX] + PC_STEP_W;
    end

    // When push and pop are both asserted, they cancel and SP holds.
    if (spPush && !spPop) begin
      regs_d[SP_IDX] = regs_q[SP_IDX] - ONE_W;
    end else if (spPop && !spPush) begin
      regs_d[SP_IDX] = regs_q[SP_IDX] + ONE_W;
    end

    if (!notLoad) begin
      regs_d[wSel] = yBus;
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[PC_IDX] <= RESET_PC_W;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads come from the registered state only. There is no bypass, so a read
  // in the same cycle as a write returns the old value.
  assign a_data = regs_q[aSel];
  assign aBus   = notAOE ? {WIDTH{1'bz}} : a_data;
  assign bBus   = regs_q[bSel];
  assign pcOut  = regs_q[PC_IDX];
  assign spOut  = regs_q[SP_IDX];

endmodule
